spi_write: RTL and testbench
============================

Name: spi_write

Overview:
- Serial transmitter for the SD-card SPI command path.
- Takes a parallel frame of outByteSize bytes and shifts it out MSB-first on bitOut (MOSI), one bit per spiClock rising edge.
- Optionally appends a 7-bit CRC7 and the SD end bit '1', so a 5-byte command (CMD index + argument) goes out as a complete 48-bit SD command frame.
- Uses the same start/finish level handshake as the SPI receive block, so the command controller can chain write then read.

Parameters:
- outByteSize, 1, number of payload bytes sent per transaction (1..8).
- appendCrc, 0, 1 = append CRC7 (7 bits) plus end bit '1' after the payload; 0 = payload only.

Ports:
- spiClock, input, 1, SPI bit clock; all state updates on its rising edge.
- resetN, input, 1, asynchronous active-low reset.
- start, input, 1, level request; a transaction begins when it is sampled high in IDLE.
- byteIn, input, outByteSize*8, payload; sampled only on the start-accept edge.
- bitOut, output, 1, serial data (MOSI); idles high.
- finish, output, 1, high from end of frame until start is sampled low.
- busy, output, 1, high while bits are being shifted (SHIFT, CRC, STOP).

Behaviour:
- Reset (resetN low, asynchronous): state=IDLE, bitOut=1, finish=0, busy=0, shift register=0, CRC register=0, counter=0.
- Frame length L = outByteSize*8 + (appendCrc ? 8 : 0).
- IDLE:
  - On an edge with start=1: load byteIn into the shift register, drive bitOut<=byteIn MSB, counter<=outByteSize*8-1, CRC<=0 then absorb the MSB, busy<=1, go SHIFT.
  - start=0: hold. bitOut=1.
- SHIFT:
  - Each edge drives the next payload bit and absorbs it into CRC.
  - When the counter reaches 0 after the last payload bit has been held one cycle: go CRC if appendCrc, else DONE.
- CRC:
  - 7 edges drive CRC[6] down to CRC[0].
  - The next edge drives the end bit '1' (STOP state).
- STOP: the '1' is held for one cycle.
- Frame end: bit i of the frame (i=0..L-1) is on bitOut during the cycle after edge k+i, where k is the accept edge. On edge k+L: bitOut<=1, busy<=0, finish<=1, go DONE.
- DONE:
  - Hold finish=1 while start=1.
  - On an edge with start=0: finish<=0, go IDLE.
  - A new frame needs at least one edge with start=0 between transactions.
- CRC7: polynomial x^7+x^3+1, init 0, computed over payload bits in transmit order; serial update uses fb = bit ^ crc[6].
- start deasserted mid-frame: ignored; the frame completes. On reaching DONE with start already low, finish pulses for exactly one cycle.
- byteIn changes mid-frame: no effect.
- resetN asserted mid-frame: immediate abort to the reset values; no partial finish.
- start high in the same cycle resetN is released: accepted on the first rising edge after release.

Decomposition:
- Shared SD/SPI package:
  - state encoding (IDLE, SHIFT, CRC, STOP, DONE);
  - CRC7 polynomial constant 7'h09;
  - SD end-bit constant 1'b1;
  - idle MOSI level 1'b1.
- One sub-module, crc7_serial:
  - ports: clock, resetN, clear, enable, bitIn, crc[6:0];
  - reusable later for response CRC checking on the receive side.

Test Plan:
1. outByteSize=1, appendCrc=0, byteIn=8'hA5, start held high → bitOut 1,0,1,0,0,1,0,1 on 8 consecutive cycles; finish=1 on edge k+8; busy=0 after; bitOut=1 after. Drop start → finish=0 next edge.
2. outByteSize=5, appendCrc=1, byteIn=40'h40_00000000 (CMD0) → 48 bits = 40 00 00 00 00 95; finish on edge k+48.
3. outByteSize=5, appendCrc=1, byteIn=40'h48_000001AA (CMD8) → trailing byte 8'h87 (CRC7 7'h43 plus end bit).
4. Drop start at bit 3 of a 0xA5 frame → full frame still sent; finish high for exactly one cycle; back in IDLE.
5. Assert resetN low at bit 20 of the CMD0 frame → bitOut=1, busy=0, finish=0 immediately (asynchronous). After release, a new start sends a correct full frame.
6. Keep start high after finish (no low gap) → no second frame; finish stays 1. Then start low for one edge, then high → second frame begins correctly.

Source files
------------

// File: rtl/spi_write_pkg.sv
// Shared SD/SPI definitions: transmit FSM encoding, CRC7 constants and the serial CRC7 step.
package spi_write_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CRC   = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam logic       SD_END_BIT = 1'b1;
    localparam logic       MOSI_IDLE  = 1'b1;

    // One bit of x^7+x^3+1, MSB-first message order.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 accumulator; clear together with enable restarts from zero and absorbs bitIn.
module crc7_serial
    import spi_write_pkg::*;
(
    input  logic       clock,
    input  logic       resetN,
    input  logic       clear,
    input  logic       enable,
    input  logic       bitIn,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (enable) begin
            crc_d = crc7_step(clear ? 7'h00 : crc_q, bitIn);
        end else if (clear) begin
            crc_d = 7'h00;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_write.sv
// SD-card SPI transmitter: shifts a parallel frame out MSB-first, optionally followed by CRC7 and end bit.
// Level start/finish handshake; bitOut idles high, busy covers the shifted bits.
module spi_write
    import spi_write_pkg::*;
#(
    parameter int outByteSize = 1,
    parameter int appendCrc   = 0
) (
    input  logic                     spiClock,
    input  logic                     resetN,
    input  logic                     start,
    input  logic [outByteSize*8-1:0] byteIn,
    output logic                     bitOut,
    output logic                     finish,
    output logic                     busy
);

    localparam int         W       = outByteSize * 8;
    localparam logic [5:0] CNT_PAY = 6'(W - 1);
    localparam logic [5:0] CNT_CRC = 6'd6;

    state_e         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           bit_q, bit_d;
    logic           fin_q, fin_d;
    logic           busy_q, busy_d;
    logic           crc_clr, crc_en, crc_bit;
    logic [6:0]     crc_val;

    crc7_serial u_crc (
        .clock  (spiClock),
        .resetN (resetN),
        .clear  (crc_clr),
        .enable (crc_en),
        .bitIn  (crc_bit),
        .crc    (crc_val)
    );

    always_ff @(posedge spiClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= MOSI_IDLE;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == 6'd0) state_d = (appendCrc != 0) ? ST_CRC : ST_DONE;
            ST_CRC:   if (cnt_q == 6'd0) state_d = ST_STOP;
            ST_STOP:  state_d = ST_DONE;
            ST_DONE:  if (!start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The CRC absorbs each payload bit on the same edge that drives it onto bitOut.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        fin_d   = fin_q;
        busy_d  = busy_q;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_d = MOSI_IDLE;
                if (start) begin
                    shift_d = byteIn;
                    bit_d   = byteIn[W-1];
                    cnt_d   = CNT_PAY;
                    crc_clr = 1'b1;
                    crc_en  = 1'b1;
                    crc_bit = byteIn[W-1];
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 6'd0) begin
                    shift_d = shift_q << 1;
                    bit_d   = shift_q[W-2];
                    cnt_d   = cnt_q - 6'd1;
                    crc_en  = 1'b1;
                    crc_bit = shift_q[W-2];
                end else if (appendCrc != 0) begin
                    shift_d = {crc_val, {(W-7){1'b0}}};
                    bit_d   = crc_val[6];
                    cnt_d   = CNT_CRC;
                end else begin
                    bit_d  = MOSI_IDLE;
                    busy_d = 1'b0;
                    fin_d  = 1'b1;
                end
            end
            ST_CRC: begin
                if (cnt_q != 6'd0) begin
                    shift_d = shift_q << 1;
                    bit_d   = shift_q[W-2];
                    cnt_d   = cnt_q - 6'd1;
                end else begin
                    bit_d = SD_END_BIT;
                end
            end
            ST_STOP: begin
                bit_d  = MOSI_IDLE;
                busy_d = 1'b0;
                fin_d  = 1'b1;
            end
            ST_DONE: begin
                bit_d = MOSI_IDLE;
                if (!start) fin_d = 1'b0;
            end
            default: begin
                bit_d  = MOSI_IDLE;
                busy_d = 1'b0;
                fin_d  = 1'b0;
            end
        endcase
    end

    assign bitOut = bit_q;
    assign finish = fin_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_spi_write.sv
// Checks three spi_write configurations against directed SD frames and a division-based CRC7 model.
module tb_spi_write;

    localparam int NB [3] = '{1, 5, 2};
    localparam bit CF [3] = '{1'b0, 1'b1, 1'b1};

    logic        clk;
    logic        rst_n;
    logic [2:0]  st;
    logic [63:0] bin [3];
    logic [2:0]  bit_o, fin_o, busy_o;

    int total = 0;
    int bad   = 0;

    spi_write #(.outByteSize(1), .appendCrc(0)) u0 (
        .spiClock(clk), .resetN(rst_n), .start(st[0]), .byteIn(bin[0][7:0]),
        .bitOut(bit_o[0]), .finish(fin_o[0]), .busy(busy_o[0]));
    spi_write #(.outByteSize(5), .appendCrc(1)) u1 (
        .spiClock(clk), .resetN(rst_n), .start(st[1]), .byteIn(bin[1][39:0]),
        .bitOut(bit_o[1]), .finish(fin_o[1]), .busy(busy_o[1]));
    spi_write #(.outByteSize(2), .appendCrc(1)) u2 (
        .spiClock(clk), .resetN(rst_n), .start(st[2]), .byteIn(bin[2][15:0]),
        .bitOut(bit_o[2]), .finish(fin_o[2]), .busy(busy_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [63:0] m, input int nbits);
        logic [70:0] r;
        r = 71'(m) << 7;
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) r = r ^ (71'(8'h89) << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic void build(input logic [63:0] p, input int nb, input bit c,
                                  output logic [71:0] f, output int len);
        logic [63:0] m;
        m   = (nb >= 8) ? p : (p & ((64'd1 << (nb * 8)) - 64'd1));
        f   = 72'(m);
        len = nb * 8;
        if (c) begin
            f   = (f << 8) | 72'({crc7_ref(m, nb * 8), 1'b1});
            len = len + 8;
        end
    endfunction

    // Called just after a negedge; returns just after a negedge with start low and the DUT idle.
    task automatic run_frame(input int idx, input logic [63:0] p, input logic [71:0] exp,
                             input int len, input int drop_at, input int hold, input string name);
        logic [71:0] got;
        logic        busy_all, fin_any;
        got      = '0;
        busy_all = 1'b1;
        fin_any  = 1'b0;
        st[idx]  = 1'b1;
        bin[idx] = p;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) bin[idx] = {$urandom, $urandom};
            got[len-1-i] = bit_o[idx];
            busy_all     = busy_all & busy_o[idx];
            fin_any      = fin_any | fin_o[idx];
            if (i == drop_at) st[idx] = 1'b0;
        end
        chk({name, "_frame"}, got, exp);
        chk({name, "_busy_during"}, 72'(busy_all), 72'(1));
        chk({name, "_finish_early"}, 72'(fin_any), 72'(0));
        @(negedge clk);
        chk({name, "_end_fin_busy_bit"}, 72'({fin_o[idx], busy_o[idx], bit_o[idx]}), 72'(3'b101));
        if (st[idx]) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({name, "_hold"}, 72'({fin_o[idx], busy_o[idx], bit_o[idx]}), 72'(3'b101));
            end
        end
        st[idx] = 1'b0;
        @(negedge clk);
        chk({name, "_released"}, 72'({fin_o[idx], busy_o[idx], bit_o[idx]}), 72'(3'b001));
    endtask

    typedef struct {
        int          idx;
        logic [63:0] payload;
        logic [71:0] exp;
        int          len;
        int          drop_at;
        int          hold;
        string       name;
    } vec_t;

    vec_t        vecs [4];
    logic [71:0] f;
    int          len, idx, drop, hold;
    logic [63:0] p;

    initial begin
        rst_n = 1'b0;
        st    = '0;
        for (int i = 0; i < 3; i++) bin[i] = '0;

        vecs[0] = '{0, 64'hA5,           72'hA5,             8,  -1, 1, "a5"};
        vecs[1] = '{1, 64'h40_00000000,  72'h40_0000_0000_95, 48, -1, 0, "cmd0"};
        vecs[2] = '{1, 64'h48_000001AA,  72'h48_0000_01AA_87, 48, -1, 2, "cmd8"};
        vecs[3] = '{0, 64'hA5,           72'hA5,             8,   3, 0, "a5_drop"};

        #12;
        chk("reset_state", 72'({bit_o, busy_o, fin_o}), 72'({3'b111, 3'b000, 3'b000}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 72'({bit_o, busy_o, fin_o}), 72'({3'b111, 3'b000, 3'b000}));

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].idx, vecs[v].payload, vecs[v].exp, vecs[v].len,
                      vecs[v].drop_at, vecs[v].hold, vecs[v].name);
        end

        // Reset mid-frame aborts asynchronously; start held through release is taken on the first edge.
        st[1]  = 1'b1;
        bin[1] = 64'h40_00000000;
        for (int i = 0; i <= 20; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_abort", 72'({bit_o[1], busy_o[1], fin_o[1]}), 72'(3'b100));
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 64'h40_00000000, 72'h40_0000_0000_95, 48, -1, 0, "cmd0_after_reset");

        // No gap after finish: no second frame, then a single low edge re-arms.
        run_frame(0, 64'h3C, 72'h3C, 8, -1, 4, "nogap_first");
        run_frame(0, 64'hC3, 72'hC3, 8, -1, 0, "nogap_second");

        for (int r = 0; r < 10; r++) begin
            idx = $urandom_range(0, 2);
            p   = {$urandom, $urandom};
            build(p, NB[idx], CF[idx], f, len);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            hold = $urandom_range(0, 2);
            run_frame(idx, p, f, len, drop, hold, $sformatf("rand%0d_u%0d", r, idx));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
